// File: rtl/i3c_ahb_req_arbiter.sv
// Two-requester round-robin AHB-Lite master issuing one SINGLE NONSEQ transfer at a time.
// Optional data-phase stall timeout with a recovery STALL state: define I3C_AHB_ARB_TIMEOUT_EN.
module i3c_ahb_req_arbiter #(
  parameter int unsigned AhbDataWidth  = 32,
  parameter int unsigned AhbAddrWidth  = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [1:0]                    req_i,
  input  logic [1:0]                    we_i,
  input  logic [2*AhbAddrWidth-1:0]     addr_i,
  input  logic [2*AhbDataWidth-1:0]     wdata_i,
  input  logic [2*(AhbDataWidth/8)-1:0] wstrb_i,
  output logic [1:0]                    ack_o,
  output logic                          err_o,
  output logic [AhbDataWidth-1:0]       rdata_o,
  output logic [AhbAddrWidth-1:0]       haddr_o,
  output logic [1:0]                    htrans_o,
  output logic                          hwrite_o,
  output logic [2:0]                    hsize_o,
  output logic [2:0]                    hburst_o,
  output logic [3:0]                    hprot_o,
  output logic [AhbDataWidth-1:0]       hwdata_o,
  output logic [AhbDataWidth/8-1:0]     hwstrb_o,
  output logic                          hsel_o,
  output logic                          hready_o,
  input  logic [AhbDataWidth-1:0]       hrdata_i,
  input  logic                          hreadyout_i,
  input  logic                          hresp_i,
  output logic [2:0]                    dbg_state_o
);

  localparam int unsigned SW = AhbDataWidth / 8;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StAddr  = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StResp  = 3'd3;
`ifdef I3C_AHB_ARB_TIMEOUT_EN
  localparam logic [2:0] StStall = 3'd4;
`endif

  localparam logic [1:0] HTransIdle   = 2'b00;
  localparam logic [1:0] HTransNonseq = 2'b10;
  localparam logic [2:0] HSize        = (AhbDataWidth == 64) ? 3'b011 : 3'b010;

  // Requester handshake: req_i[n] and its we/addr/wdata/wstrb stay stable until the cycle
  // ack_o[n] is high; the command is latched at grant, so dropping req_i later cancels nothing.
  logic [2:0]              state_q, state_d;
  logic                    rr_last_q, rr_last_d;
  logic                    grant_q, grant_d;
  logic                    we_q, we_d;
  logic [AhbAddrWidth-1:0] addr_q, addr_d;
  logic [AhbDataWidth-1:0] wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic [AhbDataWidth-1:0] rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    grant_sel;

`ifdef I3C_AHB_ARB_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TimeoutCycles);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 16) ? 16 : CntRaw);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timed_out_q, timed_out_d;
`endif

  // Contention goes to the requester not served last; a lone requester always wins.
  always_comb begin
    if (req_i == 2'b11) grant_sel = ~rr_last_q;
    else                grant_sel = req_i[1];
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef I3C_AHB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
`endif
    case (state_q)
      StIdle: begin
        if (|req_i) begin
          grant_d   = grant_sel;
          rr_last_d = grant_sel;
          we_d      = we_i[grant_sel];
          addr_d    = grant_sel ? addr_i[2*AhbAddrWidth-1:AhbAddrWidth] : addr_i[AhbAddrWidth-1:0];
          wdata_d   = grant_sel ? wdata_i[2*AhbDataWidth-1:AhbDataWidth] : wdata_i[AhbDataWidth-1:0];
          wstrb_d   = grant_sel ? wstrb_i[2*SW-1:SW] : wstrb_i[SW-1:0];
          rdata_d   = '0;
          err_d     = 1'b0;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (hreadyout_i) begin
          state_d = StData;
`ifdef I3C_AHB_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      StData: begin
        // hresp_i with hreadyout_i low is the first half of a two-cycle ERROR; keep waiting.
        if (hreadyout_i) begin
          err_d   = hresp_i;
          rdata_d = (!we_q && !hresp_i) ? hrdata_i : '0;
          state_d = StResp;
        end
`ifdef I3C_AHB_ARB_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          err_d       = 1'b1;
          rdata_d     = '0;
          timed_out_d = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
`endif
      end
      StResp: begin
`ifdef I3C_AHB_ARB_TIMEOUT_EN
        state_d     = timed_out_q ? StStall : StIdle;
        timed_out_d = 1'b0;
`else
        state_d = StIdle;
`endif
      end
`ifdef I3C_AHB_ARB_TIMEOUT_EN
      // The abandoned slave transfer must finish before anyone else may use the bus.
      StStall: begin
        if (hreadyout_i) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rr_last_q <= 1'b1;
      grant_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef I3C_AHB_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end
`endif

  assign htrans_o    = (state_q == StAddr) ? HTransNonseq : HTransIdle;
  assign hsel_o      = (state_q == StAddr);
  assign haddr_o     = addr_q;
  assign hwrite_o    = we_q;
  assign hsize_o     = HSize;
  assign hburst_o    = 3'b000;
  assign hprot_o     = 4'b0011;
  assign hwdata_o    = (state_q == StData) ? wdata_q : '0;
  assign hwstrb_o    = (state_q == StData) ? wstrb_q : '0;
  assign hready_o    = hreadyout_i;
  assign ack_o       = (state_q == StResp) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign err_o       = (state_q == StResp) && err_q;
  assign rdata_o     = (state_q == StResp) ? rdata_q : '0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i3c_ahb_req_arbiter.sv
// Directed bench for i3c_ahb_req_arbiter: behavioural AHB slave, scoreboard queues and a monitor.
`timescale 1ns/1ps
module tb_i3c_ahb_req_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
`ifdef I3C_AHB_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [15:0] cyc = '0;
  always @(posedge clk_i) cyc <= cyc + 16'd1;

  logic [1:0]      req_i, we_i;
  logic [2*AW-1:0] addr_i;
  logic [2*DW-1:0] wdata_i;
  logic [2*SW-1:0] wstrb_i;
  logic [1:0]      ack_o, htrans_o;
  logic            err_o, hwrite_o, hsel_o, hready_o;
  logic [DW-1:0]   rdata_o, hwdata_o, hrdata_i;
  logic [AW-1:0]   haddr_o;
  logic [2:0]      hsize_o, hburst_o, dbg_state_o;
  logic [3:0]      hprot_o;
  logic [SW-1:0]   hwstrb_o;
  logic            hreadyout_i, hresp_i;

  i3c_ahb_req_arbiter #(.AhbDataWidth(DW), .AhbAddrWidth(AW), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
    .hburst_o(hburst_o), .hprot_o(hprot_o), .hwdata_o(hwdata_o), .hwstrb_o(hwstrb_o),
    .hsel_o(hsel_o), .hready_o(hready_o), .hrdata_i(hrdata_i), .hreadyout_i(hreadyout_i),
    .hresp_i(hresp_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- behavioural slave ----------------
  logic        sl_dp = 1'b0;
  int          sl_cnt = 0;
  int          cfg_wait = 0;
  logic        cfg_err = 1'b0;
  logic        cfg_hold = 1'b0;
  logic [31:0] cfg_rdata = '0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      sl_dp  <= 1'b0;
      sl_cnt <= 0;
    end else if (sl_dp && hreadyout_i) begin
      sl_dp <= 1'b0;
    end else if (sl_dp) begin
      sl_cnt <= sl_cnt + 1;
    end else if (hsel_o && htrans_o == 2'b10 && hreadyout_i) begin
      sl_dp  <= 1'b1;
      sl_cnt <= 0;
    end
  end

  assign hreadyout_i = !sl_dp || (!cfg_hold && sl_cnt >= cfg_wait + (cfg_err ? 1 : 0));
  assign hresp_i     = sl_dp && cfg_err && sl_cnt >= cfg_wait;
  assign hrdata_i    = sl_dp ? cfg_rdata : '0;

  // ---------------- scoreboard ----------------
  // ack entry: {ack[50:49], err[48], rdata[47:16], ack_cycle[15:0]}
  // addr entry: {we[68], addr[67:36], wdata[35:4], wstrb[3:0]}
  logic [50:0] exp_q[$];
  logic [68:0] exp_a_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input int id, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    we_i[id]             = we;
    addr_i[id*AW +: AW]  = a;
    wdata_i[id*DW +: DW] = d;
    wstrb_i[id*SW +: SW] = s;
    req_i[id]            = 1'b1;
  endtask

  task automatic push_addr(input int id);
    exp_a_q.push_back({we_i[id], addr_i[id*AW +: AW], wdata_i[id*DW +: DW], wstrb_i[id*SW +: SW]});
  endtask

  task automatic issue(input int id, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    drive(id, we, a, d, s);
    push_addr(id);
  endtask

  task automatic expect_ack(input int id, input logic err, input logic [31:0] rd, input logic [15:0] at);
    exp_q.push_back({(id == 1) ? 2'b10 : 2'b01, err, rd, at});
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_done: %0d acks outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Requesters release req_i once they see their ack.
  initial forever begin
    @(negedge clk_i);
    if (ack_o[0]) req_i[0] = 1'b0;
    if (ack_o[1]) req_i[1] = 1'b0;
  end

  // ---------------- monitor ----------------
  logic [68:0] cur_a = '0;
  logic [50:0] cur_e;
  logic        prev_ack = 1'b0;

  initial forever begin
    @(negedge clk_i);
    if (hsel_o && htrans_o == 2'b10 && hreadyout_i) begin
      if (exp_a_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL addr_phase: unexpected NONSEQ haddr=0x%0h, expected none", haddr_o);
      end else begin
        cur_a = exp_a_q.pop_front();
        chk("haddr", 64'(haddr_o), 64'(cur_a[67:36]));
        chk("hwrite", 64'(hwrite_o), 64'(cur_a[68]));
      end
    end
    if (sl_dp && cur_a[68]) begin
      chk("hwdata", 64'(hwdata_o), 64'(cur_a[35:4]));
      chk("hwstrb", 64'(hwstrb_o), 64'(cur_a[3:0]));
    end
    if (ack_o != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL ack: unexpected ack_o=%b, expected none", ack_o);
      end else begin
        cur_e = exp_q.pop_front();
        chk("ack", 64'(ack_o), 64'(cur_e[50:49]));
        chk("err", 64'(err_o), 64'(cur_e[48]));
        chk("rdata", 64'(rdata_o), 64'(cur_e[47:16]));
        chk("ack_cycle", 64'(cyc), 64'(cur_e[15:0]));
      end
    end else if (prev_ack) begin
      chk("rdata_after_resp", 64'(rdata_o), 64'd0);
    end
    prev_ack = (ack_o != 2'b00);
  end

  // ---------------- stimulus ----------------
  logic [15:0] c0;

  initial begin
    rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_htrans", 64'(htrans_o), 64'd0);
    chk("rst_hsel", 64'(hsel_o), 64'd0);
    chk("rst_ack", 64'(ack_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("rst_haddr", 64'(haddr_o), 64'd0);
    chk("rst_hwdata", 64'(hwdata_o), 64'd0);
    chk("rst_hwstrb", 64'(hwstrb_o), 64'd0);
    chk("rst_hwrite", 64'(hwrite_o), 64'd0);
    chk("rst_state", 64'(dbg_state_o), 64'd0);
    chk("hsize", 64'(hsize_o), 64'd2);
    chk("hburst", 64'(hburst_o), 64'd0);
    chk("hprot", 64'(hprot_o), 64'd3);
    chk("hready_loop", 64'(hready_o), 64'(hreadyout_i));
    tick();
    rst_i = 1'b0;
    tick();

    // Single read, zero waits: ack three cycles after the request.
    cfg_rdata = 32'hDEAD_BEEF;
    issue(0, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
    expect_ack(0, 1'b0, 32'hDEAD_BEEF, cyc + 16'd3);
    wait_done(20);

    // Both requesting straight out of reset: 0 first, 1 one IDLE cycle later.
    reset_dut();
    issue(0, 1'b1, 32'h0000_0100, 32'hA5A5_0001, 4'hF);
    issue(1, 1'b1, 32'h0000_0200, 32'h5A5A_0002, 4'h3);
    expect_ack(0, 1'b0, 32'h0, cyc + 16'd3);
    expect_ack(1, 1'b0, 32'h0, cyc + 16'd7);
    wait_done(30);

    // Four wait states on a write, then two on a read from requester 1.
    cfg_wait = 4;
    issue(0, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b1100);
    expect_ack(0, 1'b0, 32'h0, cyc + 16'd7);
    wait_done(30);
    cfg_wait  = 2;
    cfg_rdata = 32'h0BAD_F00D;
    issue(1, 1'b0, 32'h0000_0308, 32'h0, 4'h0);
    expect_ack(1, 1'b0, 32'h0BAD_F00D, cyc + 16'd5);
    wait_done(30);
    cfg_wait = 0;

    // Two-cycle ERROR on a read: err set, read data suppressed.
    cfg_err   = 1'b1;
    cfg_rdata = 32'h1234_5678;
    issue(1, 1'b0, 32'h0000_040C, 32'h0, 4'h0);
    expect_ack(1, 1'b1, 32'h0, cyc + 16'd4);
    wait_done(30);
    cfg_err = 1'b0;

    // Reset during DATA: no ack, then requester 0 wins again despite having been served last.
    cfg_wait = 10;
    issue(0, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    tick();
    tick();
    chk("in_data_state", 64'(dbg_state_o), 64'd2);
    drive(1, 1'b1, 32'h0000_0600, 32'h1111_2222, 4'hF);
    rst_i = 1'b1;
    cfg_wait = 0;
    cfg_rdata = 32'h0000_5555;
    @(negedge clk_i);
    chk("rst_mid_htrans", 64'(htrans_o), 64'd0);
    chk("rst_mid_hsel", 64'(hsel_o), 64'd0);
    chk("rst_mid_ack", 64'(ack_o), 64'd0);
    tick();
    rst_i = 1'b0;
    push_addr(0);
    push_addr(1);
    expect_ack(0, 1'b0, 32'h0000_5555, cyc + 16'd3);
    expect_ack(1, 1'b0, 32'h0, cyc + 16'd7);
    wait_done(30);

`ifdef I3C_AHB_ARB_TIMEOUT_EN
    // Slave never readies: timeout error at DATA+16, then no NONSEQ until hreadyout_i returns.
    cfg_hold  = 1'b1;
    cfg_rdata = 32'hFEED_FACE;
    c0 = cyc;
    issue(0, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
    expect_ack(0, 1'b1, 32'h0, c0 + 16'd18);
    repeat (18) tick();
    issue(1, 1'b0, 32'h0000_0800, 32'h0, 4'h0);
    repeat (6) begin
      @(negedge clk_i);
      chk("stall_htrans", 64'(htrans_o), 64'd0);
      chk("stall_hsel", 64'(hsel_o), 64'd0);
      tick();
    end
    cfg_hold = 1'b0;
    expect_ack(1, 1'b0, 32'hFEED_FACE, cyc + 16'd4);
    wait_done(30);
`else
    c0 = cyc;
`endif

    chk("addr_q_drained", 64'(exp_a_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish, expected completion by 200000 ns");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
